// File: rtl/flash_mem_responder.sv
// Memory-bus slave that serves aligned word reads from a SPI NOR flash using the 0x03 READ command.
// Writes, misaligned and out-of-window accesses get a one-cycle error response without touching SPI.
module flash_mem_responder #(
    parameter int unsigned MEM_W     = 32,
    parameter int unsigned CLK_DIV   = 2,
    parameter logic [31:0] ADDR_BASE = 32'h2000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0100_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_req_i,
    input  logic [31:0]        mem_addr_i,
    input  logic               mem_we_i,
    input  logic [MEM_W/8-1:0] mem_be_i,
    input  logic [MEM_W-1:0]   mem_wdata_i,
    output logic               mem_rvalid_o,
    output logic               mem_err_o,
    output logic [MEM_W-1:0]   mem_rdata_o,
    output logic               busy_o,
    output logic               spi_cs_n_o,
    output logic               spi_sck_o,
    output logic               spi_mosi_o,
    input  logic               spi_miso_i
);
    localparam int unsigned TOTAL_BITS = 32 + MEM_W;
    localparam int unsigned BIT_W      = $clog2(TOTAL_BITS + 1);
    localparam int unsigned DIV_W      = $clog2(2 * CLK_DIV);

    localparam logic [BIT_W-1:0] BIT_CMD_LAST = BIT_W'(31);
    localparam logic [BIT_W-1:0] BIT_TAIL     = BIT_W'(TOTAL_BITS);
    localparam logic [DIV_W-1:0] DIV_RISE     = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HIGH     = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [7:0]       CMD_READ     = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        CMD,
        DATA,
        RESP,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [31:0]        tx_q, tx_d;
    logic [MEM_W-1:0]   rx_q, rx_d;
    logic [MEM_W-1:0]   rdata_q, rdata_d;
    logic               cs_n_q, cs_n_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;

    logic [32:0]        offset;
    logic               addr_ok;
    logic [31:0]        cmd_word;
    logic [MEM_W-1:0]   rx_le;

    logic               unused_bus;
    assign unused_bus = ^{mem_be_i, mem_wdata_i};

    // 33-bit offset so a window ending at 2^32 cannot wrap the compare
    always_comb begin
        offset   = {1'b0, mem_addr_i} - {1'b0, ADDR_BASE};
        addr_ok  = (mem_addr_i[1:0] == 2'b00) && (mem_addr_i >= ADDR_BASE)
                   && (offset < {1'b0, ADDR_SIZE});
        cmd_word = {CMD_READ, offset[23:0]};
    end

    // Bytes arrive MSB-first in rx_q; the first byte lands in the top and goes to rdata[7:0]
    always_comb begin
        rx_le = '0;
        for (int i = 0; i < MEM_W / 8; i++) begin
            rx_le[8*i +: 8] = rx_q[MEM_W-1-8*i -: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        div_d   = div_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        cs_n_d  = cs_n_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;

        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    if (mem_we_i || !addr_ok) begin
                        state_d = ERR;
                        rdata_d = '0;
                    end else begin
                        state_d = CMD;
                        bit_d   = '0;
                        div_d   = '0;
                        tx_d    = cmd_word;
                        cs_n_d  = 1'b0;
                        sck_d   = 1'b0;
                        mosi_d  = cmd_word[31];
                    end
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            CMD, DATA: begin
                // One trailing SCK-low cycle after the last bit gives CS hold before deselect
                if (state_q == DATA && bit_q == BIT_TAIL) begin
                    state_d = RESP;
                    cs_n_d  = 1'b1;
                    rdata_d = rx_le;
                end else begin
                    if (state_q == DATA && div_q == DIV_RISE) begin
                        rx_d = {rx_q[MEM_W-2:0], spi_miso_i};
                    end
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        bit_d = bit_q + 1'b1;
                        sck_d = 1'b0;
                        if (state_q == CMD) begin
                            tx_d   = {tx_q[30:0], 1'b0};
                            mosi_d = tx_q[30];
                            if (bit_q == BIT_CMD_LAST) begin
                                state_d = DATA;
                                mosi_d  = 1'b0;
                            end
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                        sck_d = (div_d >= DIV_HIGH);
                    end
                end
            end
            RESP: begin
                state_d = GAP;
                div_d   = '0;
            end
            GAP: begin
                if (div_q == DIV_LAST) begin
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            div_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

    assign mem_rvalid_o = (state_q == RESP) || (state_q == ERR);
    assign mem_err_o    = (state_q == ERR);
    assign mem_rdata_o  = rdata_q;
    assign busy_o       = (state_q != IDLE);
    assign spi_cs_n_o   = cs_n_q;
    assign spi_sck_o    = sck_q;
    assign spi_mosi_o   = mosi_q;
endmodule

// File: tb/tb_flash_mem_responder.sv
// Bench for flash_mem_responder: default instance (32-bit, CLK_DIV=2) and a 64-bit CLK_DIV=1 instance,
// each attached to a behavioural SPI flash whose contents are a fixed function of the byte offset.
module tb_flash_mem_responder;
    localparam int W0 = 32;
    localparam int C0 = 2;
    localparam int W1 = 64;
    localparam int C1 = 1;
    localparam int LAT0 = 1 + (32 + W0) * 2 * C0;
    localparam int LAT1 = 1 + (32 + W1) * 2 * C1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        req0 = 0, we0 = 0;
    logic [31:0] addr0 = '0;
    logic [3:0]  be0 = '0;
    logic [31:0] wdata0 = '0;
    logic        rvalid0, err0, busy0, cs0_n, sck0, mosi0;
    logic        miso0 = 1'b0;
    logic [31:0] rdata0;

    logic        req1 = 0, we1 = 0;
    logic [31:0] addr1 = '0;
    logic [7:0]  be1 = '0;
    logic [63:0] wdata1 = '0;
    logic        rvalid1, err1, busy1, cs1_n, sck1, mosi1;
    logic        miso1 = 1'b0;
    logic [63:0] rdata1;

    flash_mem_responder dut0 (
        .clk(clk), .rst(rst), .mem_req_i(req0), .mem_addr_i(addr0), .mem_we_i(we0),
        .mem_be_i(be0), .mem_wdata_i(wdata0), .mem_rvalid_o(rvalid0), .mem_err_o(err0),
        .mem_rdata_o(rdata0), .busy_o(busy0), .spi_cs_n_o(cs0_n), .spi_sck_o(sck0),
        .spi_mosi_o(mosi0), .spi_miso_i(miso0)
    );

    flash_mem_responder #(.MEM_W(W1), .CLK_DIV(C1)) dut1 (
        .clk(clk), .rst(rst), .mem_req_i(req1), .mem_addr_i(addr1), .mem_we_i(we1),
        .mem_be_i(be1), .mem_wdata_i(wdata1), .mem_rvalid_o(rvalid1), .mem_err_o(err1),
        .mem_rdata_o(rdata1), .busy_o(busy1), .spi_cs_n_o(cs1_n), .spi_sck_o(sck1),
        .spi_mosi_o(mosi1), .spi_miso_i(miso1)
    );

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000104: return 8'hEF;
            24'h000105: return 8'hBE;
            24'h000106: return 8'hAD;
            24'h000107: return 8'hDE;
            default:    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [63:0] exp_data(input logic [31:0] a, input int nbytes);
        logic [63:0] r;
        logic [23:0] off;
        r   = '0;
        off = 24'(a - 32'h2000_0000);
        for (int i = 0; i < nbytes; i++) r[8*i +: 8] = flash_byte(off + 24'(i));
        return r;
    endfunction

    function automatic bit exp_err(input logic [31:0] a, input logic w);
        longint unsigned la;
        la = a;
        return w || (la % 4 != 0) || (la < 64'h2000_0000) || (la >= 64'h2000_0000 + 64'h0100_0000);
    endfunction

    // Flash models and activity monitors
    int sck_rise0 = 0, cs_low0 = 0, rv_cnt0 = 0, mosi_bad0 = 0, f0_bits = 0;
    int sck_rise1 = 0, cs_low1 = 0, rv_cnt1 = 0, mosi_bad1 = 0, f1_bits = 0;
    logic [31:0] f0_cmd = '0, f1_cmd = '0;
    logic [7:0]  f0_byte, f1_byte;

    always @(negedge cs0_n) f0_bits = 0;
    always @(posedge sck0) begin
        sck_rise0++;
        if (cs0_n === 1'b0) begin
            if (f0_bits < 32) f0_cmd = {f0_cmd[30:0], mosi0};
            else if (mosi0 !== 1'b0) mosi_bad0++;
            f0_bits++;
        end
    end
    always @(negedge sck0) begin
        if (cs0_n === 1'b0 && f0_bits >= 32) begin
            f0_byte = flash_byte(f0_cmd[23:0] + 24'((f0_bits - 32) / 8));
            miso0 <= f0_byte[7 - ((f0_bits - 32) % 8)];
        end
    end
    always @(posedge clk) if (cs0_n === 1'b0) cs_low0++;
    always @(negedge clk) if (rvalid0 === 1'b1) rv_cnt0++;

    always @(negedge cs1_n) f1_bits = 0;
    always @(posedge sck1) begin
        sck_rise1++;
        if (cs1_n === 1'b0) begin
            if (f1_bits < 32) f1_cmd = {f1_cmd[30:0], mosi1};
            else if (mosi1 !== 1'b0) mosi_bad1++;
            f1_bits++;
        end
    end
    always @(negedge sck1) begin
        if (cs1_n === 1'b0 && f1_bits >= 32) begin
            f1_byte = flash_byte(f1_cmd[23:0] + 24'((f1_bits - 32) / 8));
            miso1 <= f1_byte[7 - ((f1_bits - 32) % 8)];
        end
    end
    always @(posedge clk) if (cs1_n === 1'b0) cs_low1++;
    always @(negedge clk) if (rvalid1 === 1'b1) rv_cnt1++;

    // Drivers: issue one request to an idle DUT, report latency from the accepting edge
    task automatic wait_idle0();
        for (int i = 0; i < 200 && busy0 !== 1'b0; i++) @(negedge clk);
    endtask

    task automatic issue0(input logic [31:0] a, input logic w, output int lat,
                          output logic e, output logic [31:0] d);
        @(negedge clk);
        req0 = 1'b1; addr0 = a; we0 = w; be0 = 4'($urandom); wdata0 = $urandom;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (rvalid0 !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        e = err0; d = rdata0;
        req0 = 1'b0; we0 = 1'b0;
        wait_idle0();
    endtask

    task automatic issue1(input logic [31:0] a, input logic w, output int lat,
                          output logic e, output logic [63:0] d);
        @(negedge clk);
        req1 = 1'b1; addr1 = a; we1 = w; be1 = 8'($urandom); wdata1 = {$urandom, $urandom};
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (rvalid1 !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        e = err1; d = rdata1;
        req1 = 1'b0; we1 = 1'b0;
        for (int i = 0; i < 200 && busy1 !== 1'b0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rvalid0, err0, busy0, cs0_n, sck0, mosi0, rdata0} !== {6'b000100, 32'h0}) begin
            n_fail++;
            $display("FAIL reset0: got %b/%h want 000100/0", {rvalid0, err0, busy0, cs0_n, sck0, mosi0}, rdata0);
        end
        n_cmp++;
        if ({rvalid1, err1, busy1, cs1_n, sck1, mosi1, rdata1} !== {6'b000100, 64'h0}) begin
            n_fail++;
            $display("FAIL reset1: got %b/%h want 000100/0", {rvalid1, err1, busy1, cs1_n, sck1, mosi1}, rdata1);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_default();
        int lat, s0, rv; logic e; logic [31:0] d;
        s0 = sck_rise0; rv = rv_cnt0;
        issue0(32'h2000_0104, 1'b0, lat, e, d);
        n_cmp++;
        if (lat !== LAT0) begin n_fail++; $display("FAIL read latency: got %0d want %0d", lat, LAT0); end
        n_cmp++;
        if ({e, d} !== {1'b0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL read data: got err=%0b %h want err=0 deadbeef", e, d); end
        n_cmp++;
        if (f0_cmd !== 32'h0300_0104) begin n_fail++; $display("FAIL read mosi cmd: got %h want 03000104", f0_cmd); end
        n_cmp++;
        if (sck_rise0 - s0 !== 64 || mosi_bad0 !== 0) begin
            n_fail++; $display("FAIL read sck/mosi: got %0d edges %0d bad want 64 edges 0 bad", sck_rise0 - s0, mosi_bad0);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rdata0 !== 32'hDEAD_BEEF || rv_cnt0 - rv !== 1) begin
            n_fail++; $display("FAIL read hold: got %h, %0d pulses want deadbeef, 1", rdata0, rv_cnt0 - rv);
        end
    endtask

    // Write plus boundary addresses around the window; expectations from the access rules
    task automatic test_errors();
        logic [31:0] addrs [5];
        logic        wes   [5];
        int lat, s0, c0; logic e; logic [31:0] d, x;
        addrs = '{32'h2000_0000, 32'h2000_0002, 32'h2100_0000, 32'h1FFF_FFFC, 32'h20FF_FFFC};
        wes   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            s0 = sck_rise0; c0 = cs_low0;
            issue0(addrs[i], wes[i], lat, e, d);
            x = 32'(exp_data(addrs[i], 4));
            if (exp_err(addrs[i], wes[i])) begin
                n_cmp++;
                if ({lat, e, d} !== {32'd0, 1'b1, 32'h0}) begin
                    n_fail++; $display("FAIL err %h: got lat=%0d err=%0b %h want lat=0 err=1 0", addrs[i], lat, e, d);
                end
                n_cmp++;
                if (sck_rise0 - s0 !== 0 || cs_low0 - c0 !== 0) begin
                    n_fail++; $display("FAIL err spi %h: got %0d sck %0d cs-low want 0 0", addrs[i], sck_rise0 - s0, cs_low0 - c0);
                end
            end else begin
                n_cmp++;
                if ({lat, e, d} !== {LAT0, 1'b0, x}) begin
                    n_fail++; $display("FAIL edge read %h: got lat=%0d err=%0b %h want lat=%0d err=0 %h", addrs[i], lat, e, d, LAT0, x);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses, gap, min_gap, rv; logic [31:0] d1, d2, x1, x2;
        pulses = 0; gap = 0; min_gap = 1000; rv = rv_cnt0; d1 = '0; d2 = '0;
        x1 = 32'(exp_data(32'h2000_0200, 4));
        x2 = 32'(exp_data(32'h2000_0300, 4));
        @(negedge clk);
        req0 = 1'b1; addr0 = 32'h2000_0200; we0 = 1'b0;
        for (int t = 0; t < 800 && pulses < 2; t++) begin
            @(negedge clk);
            if (t == 5) addr0 = 32'h2000_0300;
            if (rvalid0 === 1'b1) begin
                pulses++;
                if (pulses == 1) d1 = rdata0; else d2 = rdata0;
            end
            if (cs0_n === 1'b1) gap++;
            else begin
                if (pulses == 1 && gap > 0 && gap < min_gap) min_gap = gap;
                gap = 0;
            end
        end
        req0 = 1'b0;
        wait_idle0();
        repeat (20) @(negedge clk);
        n_cmp++;
        if (pulses !== 2 || rv_cnt0 - rv !== 2) begin
            n_fail++; $display("FAIL b2b pulses: got %0d/%0d want 2", pulses, rv_cnt0 - rv);
        end
        n_cmp++;
        if (!(min_gap >= 2 * C0 && min_gap < 1000)) begin
            n_fail++; $display("FAIL b2b cs gap: got %0d want >= %0d", min_gap, 2 * C0);
        end
        n_cmp++;
        if ({d1, d2} !== {x1, x2}) begin
            n_fail++; $display("FAIL b2b data: got %h %h want %h %h", d1, d2, x1, x2);
        end
    endtask

    task automatic test_reset_mid();
        int rv, lat; logic e; logic [31:0] d, x;
        rv = rv_cnt0;
        @(negedge clk);
        req0 = 1'b1; addr0 = 32'h2000_0400; we0 = 1'b0;
        @(posedge clk);
        repeat (40 * 2 * C0 + 3) @(negedge clk);
        n_cmp++;
        if ({busy0, cs0_n} !== 2'b10) begin n_fail++; $display("FAIL mid pre-reset: got busy/cs_n=%b want 10", {busy0, cs0_n}); end
        req0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({rvalid0, err0, busy0, cs0_n, sck0, mosi0, rdata0} !== {6'b000100, 32'h0}) begin
            n_fail++; $display("FAIL mid async reset: got %b/%h want 000100/0", {rvalid0, err0, busy0, cs0_n, sck0, mosi0}, rdata0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rv_cnt0 - rv !== 0) begin n_fail++; $display("FAIL mid no response: got %0d pulses want 0", rv_cnt0 - rv); end
        issue0(32'h2000_0000, 1'b0, lat, e, d);
        x = 32'(exp_data(32'h2000_0000, 4));
        n_cmp++;
        if ({lat, e, d} !== {LAT0, 1'b0, x}) begin
            n_fail++; $display("FAIL mid post-reset read: got lat=%0d err=%0b %h want lat=%0d err=0 %h", lat, e, d, LAT0, x);
        end
    endtask

    task automatic test_random0();
        int lat, rv, xlat; logic e, w, xe; logic [31:0] d, a, x;
        rv = rv_cnt0;
        for (int i = 0; i < 12; i++) begin
            w = 1'b0;
            case ($urandom_range(0, 7))
                0: begin a = 32'h2000_0000 + ($urandom_range(0, 32'h00FF_FFFF) & ~32'h3); w = 1'b1; end
                1: a = (32'h2000_0000 + $urandom_range(0, 32'h00FF_FFFF)) | 32'h1;
                2: a = $urandom_range(0, 32'h1FFF_FFFF);
                3: a = 32'h2100_0000 + $urandom_range(0, 32'h0FFF_FFFF);
                default: a = 32'h2000_0000 + ($urandom_range(0, 32'h00FF_FFFF) & ~32'h3);
            endcase
            xe   = exp_err(a, w);
            xlat = xe ? 0 : LAT0;
            x    = xe ? 32'h0 : 32'(exp_data(a, 4));
            issue0(a, w, lat, e, d);
            n_cmp++;
            if ({lat, e, d} !== {xlat, xe, x}) begin
                n_fail++; $display("FAIL rand0 %0d addr %h we %0b: got lat=%0d err=%0b %h want lat=%0d err=%0b %h", i, a, w, lat, e, d, xlat, xe, x);
            end
        end
        n_cmp++;
        if (rv_cnt0 - rv !== 12) begin n_fail++; $display("FAIL rand0 pulses: got %0d want 12", rv_cnt0 - rv); end
    endtask

    task automatic test_wide();
        int lat, xlat, s1; logic e, w, xe; logic [63:0] d, x; logic [31:0] a;
        s1 = sck_rise1;
        issue1(32'h2000_0010, 1'b0, lat, e, d);
        x = exp_data(32'h2000_0010, 8);
        n_cmp++;
        if ({lat, e, d} !== {LAT1, 1'b0, x}) begin
            n_fail++; $display("FAIL wide read: got lat=%0d err=%0b %h want lat=%0d err=0 %h", lat, e, d, LAT1, x);
        end
        n_cmp++;
        if (f1_cmd !== 32'h0300_0010 || sck_rise1 - s1 !== 96 || mosi_bad1 !== 0) begin
            n_fail++; $display("FAIL wide spi: got cmd %h %0d edges %0d bad want 03000010 96 0", f1_cmd, sck_rise1 - s1, mosi_bad1);
        end
        for (int i = 0; i < 6; i++) begin
            w = ($urandom_range(0, 5) == 0);
            a = 32'h2000_0000 + ($urandom_range(0, 32'h00FF_FFFF) & ~32'h3);
            if ($urandom_range(0, 5) == 0) a = a | 32'h2;
            xe   = exp_err(a, w);
            xlat = xe ? 0 : LAT1;
            x    = xe ? 64'h0 : exp_data(a, 8);
            issue1(a, w, lat, e, d);
            n_cmp++;
            if ({lat, e, d} !== {xlat, xe, x}) begin
                n_fail++; $display("FAIL rand1 %0d addr %h we %0b: got lat=%0d err=%0b %h want lat=%0d err=%0b %h", i, a, w, lat, e, d, xlat, xe, x);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_default();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random0();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end
endmodule

// File: doc/flash_mem_responder.md
FLASH_MEM_RESPONDER -- requirements
Module: flash_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- MEM_W, 32, memory bus width in bits, multiple of 8.
- CLK_DIV, 2, clk cycles per SCK half-period, at least 1.
- ADDR_BASE, 32'h2000_0000, first bus byte address mapped to flash byte 0.
- ADDR_SIZE, 32'h0100_0000, size of the mapped window in bytes, at most 2^24.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- mem_req_i, in, 1, request valid; the requester holds it until mem_rvalid_o.
- mem_addr_i, in, 32, byte address.
- mem_we_i, in, 1, write enable.
- mem_be_i, in, MEM_W/8, byte enables; ignored for reads.
- mem_wdata_i, in, MEM_W, write data; unused.
- mem_rvalid_o, out, 1, one-cycle response strobe.
- mem_err_o, out, 1, error flag, qualified by mem_rvalid_o.
- mem_rdata_o, out, MEM_W, read data, qualified by mem_rvalid_o.
- busy_o, out, 1, high in every state except IDLE.
- spi_cs_n_o, out, 1, flash chip select, active low.
- spi_sck_o, out, 1, SPI clock, SPI mode 0, idles low.
- spi_mosi_o, out, 1, serial data to the flash.
- spi_miso_i, in, 1, serial data from the flash.

Function
REQ-003 The FSM SHALL have the states IDLE, ERR, CMD, DATA, RESP and GAP, with one transaction outstanding at most.
REQ-004 In IDLE with mem_req_i=1, the block SHALL capture addr and we at that edge (the accepting edge); mem_req_i SHALL be ignored in all other states.
REQ-005 A request SHALL go to ERR if we=1, if addr[1:0]!=0, or if addr<ADDR_BASE or addr>=ADDR_BASE+ADDR_SIZE. Otherwise it SHALL go to CMD with cs_n low from the cycle after the accepting edge.
REQ-006 ERR SHALL last one cycle with rvalid=1, err=1, rdata=0, and no SPI activity, then return to IDLE.
REQ-007 CMD SHALL shift 32 bits MSB-first: the byte 0x03, then the 24-bit offset (addr-ADDR_BASE).
REQ-008 DATA SHALL shift in MEM_W bits.
REQ-009 Each bit SHALL take 2*CLK_DIV cycles: SCK low for CLK_DIV, then high for CLK_DIV.
REQ-010 MOSI SHALL change only while SCK is low, and MISO SHALL be sampled on the SCK rising transition.
REQ-011 MOSI SHALL be 0 outside CMD.
REQ-012 Received bytes SHALL be assembled little-endian: the first byte goes to rdata[7:0], and each byte is MSB-first.
REQ-013 RESP SHALL last one cycle with cs_n=1, rvalid=1, err=0 and the assembled rdata. This cycle SHALL be exactly 1+(32+MEM_W)*2*CLK_DIV cycles after the accepting edge (257 with the defaults).
REQ-014 GAP SHALL hold cs_n high for 2*CLK_DIV cycles, then enter IDLE, so that back-to-back reads honour the flash deselect time.
REQ-015 mem_rvalid_o SHALL be high for exactly one cycle per accepted request and never otherwise.
REQ-016 mem_rdata_o SHALL hold its last value between responses; it is 0 after an error.
REQ-017 A bit counter SHALL count the bits to be shifted, and a divider SHALL count the cycles within each bit. Both SHALL be sized for 32+MEM_W bits and CLK_DIV without overflow.

Reset
REQ-018 While rst=1, the outputs SHALL be: rvalid=0, err=0, rdata=0, busy=0, cs_n=1, sck=0, mosi=0, and the state SHALL be IDLE; all of these take effect immediately, regardless of clk.
REQ-019 Reset mid-transaction SHALL abort the transaction with no response; the first request after reset release SHALL be handled normally.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Read, defaults: req at 0x2000_0104 with a flash model returning EF BE AD DE -> MOSI carries 03 00 01 04, rvalid pulses 257 cycles after accept with rdata=0xDEADBEEF, err=0.
- Write: req with we=1 at 0x2000_0000 -> rvalid=err=1 and rdata=0 on the next cycle, cs_n never low.
- Misaligned or out-of-window read: addr 0x2000_0002, then 0x2100_0000 -> error response for each, no SPI activity.
- Back-to-back reads: req held high continuously -> cs_n high for at least 4 cycles between transactions, two rvalid pulses, req ignored while busy.
- Reset during DATA: rst asserted at bit 40 -> cs_n=1 and sck=0 immediately, no rvalid; a following read at 0x2000_0000 returns the correct data.
- CLK_DIV=1 with MEM_W=64: 8-byte read -> rvalid 193 cycles after accept, bytes packed little-endian.
